mem_arbiter: RTL and testbench

Shares one single-port, fixed-latency memory between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage) of the 5-stage pipeline. It serialises transactions, routes read data back to the owning stage, and produces per-stage stall signals. The pipeline uses those stalls to drive its per-stage advance enables. Data accesses have priority, and a starvation limit guarantees that fetch makes forward progress.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_starve_counter.sv | 39 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/MEM memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of issue slots in which a waiting fetch lost to data.
// Clear takes precedence over increment.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] MAX = CW'(LIMIT);

    logic [CW-1:0] count_q, count_d;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX)) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit_o = (count_q == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between IF fetch and MEM data access.
// Data wins by default; the starvation counter forces a fetch grant after repeated losses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int LW = $clog2(MEM_LATENCY + 1);
    localparam logic [LW-1:0] LAT = LW'(MEM_LATENCY);

    arb_state_t    state_q, state_d;
    owner_t        owner_q, owner_d, grant;
    logic          wr_q, wr_d;
    logic [LW-1:0] cnt_q, cnt_d;

    logic resp_cycle, issue_slot, if_elig, dm_elig;
    logic at_limit, starve_inc, starve_clr;

    // The response cycle doubles as an issue slot, giving back-to-back issue.
    assign resp_cycle = !rst && (state_q == BUSY) && (cnt_q == LW'(1));
    assign issue_slot = !rst && ((state_q == IDLE) || resp_cycle);

    assign if_rvalid = resp_cycle && (owner_q == OWN_IF);
    assign dm_rvalid = resp_cycle && (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid && !wr_q) ? mem_rdata : '0;

    // A held request is masked in its own rvalid cycle so it is never re-issued.
    assign if_elig   = if_req && !if_rvalid;
    assign dm_elig   = dm_req && !dm_rvalid;
    assign stall_if  = if_req && !if_rvalid;
    assign stall_mem = dm_req && !dm_rvalid;

    always_comb begin
        grant = OWN_NONE;
        if (issue_slot) begin
            if (if_elig && (at_limit || !dm_elig)) begin
                grant = OWN_IF;
            end else if (dm_elig) begin
                grant = OWN_DM;
            end
        end
    end

    assign mem_req   = (grant != OWN_NONE);
    assign mem_we    = (grant == OWN_DM) && dm_we;
    assign mem_addr  = (grant == OWN_IF) ? if_addr : ((grant == OWN_DM) ? dm_addr : '0);
    assign mem_wdata = (grant == OWN_DM) ? dm_wdata : '0;

    assign starve_inc = issue_slot && if_elig && (grant == OWN_DM);
    assign starve_clr = (grant == OWN_IF) || !if_req;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (starve_inc),
        .clr_i      (starve_clr),
        .at_limit_o (at_limit)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (issue_slot) begin
            if (grant != OWN_NONE) begin
                state_d = BUSY;
                owner_d = grant;
                wr_d    = mem_we;
                cnt_d   = LAT;
            end else begin
                state_d = IDLE;
                owner_d = OWN_NONE;
                wr_d    = 1'b0;
                cnt_d   = '0;
            end
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    a_no_issue_while_busy: assert property (@(posedge clk) disable iff (rst)
        ((state_q == BUSY) && !resp_cycle) |-> !mem_req);

    a_single_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(if_rvalid && dm_rvalid));

    a_if_held: assert property (@(posedge clk) disable iff (rst)
        (if_req && !if_rvalid) |=> (if_req && $stable(if_addr)));

    a_dm_held: assert property (@(posedge clk) disable iff (rst)
        (dm_req && !dm_rvalid) |=>
        (dm_req && $stable(dm_we) && $stable(dm_addr) && $stable(dm_wdata)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against a transaction-timing reference model.
// A small behavioural memory answers issues after a fixed latency.
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LAT   = 3;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MEM_LATENCY  (LAT),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0011);
    endfunction

    // Behavioural memory: 16 words aliased by addr[5:2]; write slots return junk.
    logic          mem_init = 1'b1;
    logic [15:0]   written;
    logic [DW-1:0] mem_arr [16];
    logic [DW-1:0] pipe [LAT];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= $urandom;
        if (mem_init) begin
            written <= '0;
        end else if (mem_req && mem_we) begin
            mem_arr[mem_addr[5:2]] <= mem_wdata;
            written[mem_addr[5:2]] <= 1'b1;
        end
        if (mem_req && !mem_we) begin
            pipe[0] <= written[mem_addr[5:2]] ? mem_arr[mem_addr[5:2]]
                                              : init_word(int'(mem_addr[5:2]));
        end
    end

    assign mem_rdata = pipe[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction, finishing at a known cycle number.
    bit            m_busy = 1'b0;
    int            m_owner = 0;       // 0 none, 1 fetch, 2 data
    bit            m_we = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    int            m_done = 0;
    int            m_starve = 0;
    logic [DW-1:0] sb [16];
    bit            if_pend = 1'b0;
    bit            dm_pend = 1'b0;

    task automatic drive(input int p_if, input int p_dm, input bit do_rst);
        logic [31:0] r;
        rst = do_rst;
        if (do_rst) begin
            if_req  = 1'b0;
            dm_req  = 1'b0;
            if_pend = 1'b0;
            dm_pend = 1'b0;
        end else begin
            if (!if_pend) begin
                r       = $urandom;
                if_addr = r & ~32'h3;
                if_req  = ($urandom_range(99) < p_if);
                if_pend = if_req;
            end
            if (!dm_pend) begin
                r        = $urandom;
                dm_addr  = r & ~32'h3;
                dm_wdata = $urandom;
                dm_we    = ($urandom_range(99) < 40);
                dm_req   = ($urandom_range(99) < p_dm);
                dm_pend  = dm_req;
            end
        end
    endtask

    task automatic eval_cycle();
        bit resp, e_if_rv, e_dm_rv, if_elig, dm_elig, slot;
        int win;
        int idx;
        resp    = !rst && m_busy && (cyc == m_done);
        e_if_rv = resp && (m_owner == 1);
        e_dm_rv = resp && (m_owner == 2);
        if_elig = if_req && !e_if_rv;
        dm_elig = dm_req && !e_dm_rv;
        slot    = !rst && (!m_busy || resp);
        win     = 0;
        if (slot) begin
            if (if_elig && (m_starve == LIMIT || !dm_elig)) win = 1;
            else if (dm_elig) win = 2;
        end

        check("if_rvalid", 64'(if_rvalid), 64'(e_if_rv));
        check("dm_rvalid", 64'(dm_rvalid), 64'(e_dm_rv));
        check("stall_if", 64'(stall_if), 64'(if_req && !e_if_rv));
        check("stall_mem", 64'(stall_mem), 64'(dm_req && !e_dm_rv));
        check("mem_req", 64'(mem_req), 64'(win != 0));
        check("starve_cnt", 64'(dut.u_starve.count_q), 64'(m_starve));
        if (win != 0) begin
            check("mem_we", 64'(mem_we), 64'((win == 2) && dm_we));
            check("mem_addr", 64'(mem_addr), 64'((win == 1) ? if_addr : dm_addr));
            if (win == 2) check("mem_wdata", 64'(mem_wdata), 64'(dm_wdata));
        end
        if (e_if_rv) begin
            check("if_rdata", 64'(if_rdata), 64'(m_rdata));
            check("dm_rdata_idle", 64'(dm_rdata), 64'(0));
        end
        if (e_dm_rv) begin
            check("dm_rdata", 64'(dm_rdata), 64'(m_we ? '0 : m_rdata));
            check("if_rdata_idle", 64'(if_rdata), 64'(0));
        end

        if (rst) begin
            m_busy   = 1'b0;
            m_starve = 0;
        end else begin
            if (slot) begin
                if (win == 0) begin
                    m_busy = 1'b0;
                end else begin
                    m_busy  = 1'b1;
                    m_owner = win;
                    m_done  = cyc + LAT;
                    if (win == 1) begin
                        idx     = int'(if_addr[5:2]);
                        m_we    = 1'b0;
                        m_rdata = sb[idx];
                    end else begin
                        idx  = int'(dm_addr[5:2]);
                        m_we = dm_we;
                        if (dm_we) begin
                            sb[idx] = dm_wdata;
                            m_rdata = '0;
                        end else begin
                            m_rdata = sb[idx];
                        end
                    end
                end
            end
            if (win == 1 || !if_req) m_starve = 0;
            else if (slot && if_elig && win == 2 && m_starve < LIMIT) m_starve++;
            if (e_if_rv) if_pend = 1'b0;
            if (e_dm_rv) dm_pend = 1'b0;
        end
    endtask

    task automatic run_cycle(input int p_if, input int p_dm, input bit do_rst);
        drive(p_if, p_dm, do_rst);
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) sb[i] = init_word(i);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) run_cycle(0, 0, 1'b1);
        mem_init = 1'b0;
        for (int k = 0; k < 10; k++) run_cycle(0, 0, 1'b0);
        for (int k = 0; k < 600; k++) run_cycle(60, 50, ($urandom_range(99) < 2));
        for (int k = 0; k < 300; k++) run_cycle(100, 100, ($urandom_range(149) == 0));
        for (int k = 0; k < 200; k++) run_cycle(30, 80, 1'b0);
        for (int k = 0; k < 8; k++) run_cycle(0, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
